mem_access_unit: RTL

CPU-side initiator for the data memory port, placed between the MEM pipeline stage and the byte-enable data memory. It accepts one load/store per transaction and generates address, BE and store data. It handles a req/ack handshake with wait states, then extracts and extends load data. It stalls the pipeline while busy and flags misaligned accesses and ack timeouts.

---
 rtl/mem_pkg.sv | 60 ++++++
 rtl/mem_access_unit_load_extender.sv | 30 +++
 rtl/mem_access_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory initiator: op codes, FSM states, lane enables
// and the alignment / byte-enable helpers used when an op is accepted.
package mem_pkg;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_BYTE1   = 4'b0010;
    localparam logic [3:0] BE_BYTE2   = 4'b0100;
    localparam logic [3:0] BE_BYTE3   = 4'b1000;

    function automatic logic is_store(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] lo);
        logic ok;
        case (op)
            OP_LW, OP_SW:         ok = (lo == 2'b00);
            OP_LH, OP_LHU, OP_SH: ok = ~lo[0];
            default:              ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Loads drive the same lane pattern as stores; memory treats it as informational.
    function automatic logic [3:0] be_for(input logic [2:0] op, input logic [1:0] lo);
        logic [3:0] be;
        case (op)
            OP_LW, OP_SW:         be = BE_WORD;
            OP_LH, OP_LHU, OP_SH: be = lo[1] ? BE_HALF_HI : BE_HALF_LO;
            default: begin
                case (lo)
                    2'b00:   be = BE_BYTE0;
                    2'b01:   be = BE_BYTE1;
                    2'b10:   be = BE_BYTE2;
                    default: be = BE_BYTE3;
                endcase
            end
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// Picks the addressed half/byte out of a full read word and sign- or zero-extends it.
// Store op codes produce zero so the result can be registered unconditionally.
module load_extender
    import mem_pkg::*;
(
    input  logic [2:0]  op_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [15:0] half;
    logic [7:0]  lane;

    assign half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    assign lane = rdata[{addr_lo, 3'b000} +: 8];

    always_comb begin
        data = '0;
        case (op_type)
            OP_LW:   data = rdata;
            OP_LH:   data = {{16{half[15]}}, half};
            OP_LHU:  data = {16'h0000, half};
            OP_LB:   data = {{24{lane[7]}}, lane};
            OP_LBU:  data = {24'h000000, lane};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline-side initiator for the byte-enable data memory: registers one load/store,
// runs the req/ack handshake with a timeout, then returns the extended load result.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        done,
    output logic        addr_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_pc,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    // Handshake: mem_req stays high with every mem_* output frozen from the cycle after
    // acceptance until the cycle in which mem_ack is sampled high (or the timeout hits).

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [31:0]      ext_data;
    logic             aligned, accept, misalign, timeout;

    assign aligned  = is_aligned(op_type, addr[1:0]);
    // Gated by reset so stall is low while reset is held, even with op_valid high.
    assign accept   = reset && (state == ST_IDLE) && op_valid && aligned;
    assign misalign = reset && (state == ST_IDLE) && op_valid && !aligned;
    assign timeout  = (state == ST_REQ) && !mem_ack && (cnt == CNT_W'(ACK_TIMEOUT - 1));
    assign dbg_state = state;

    load_extender u_ext (
        .op_type (op_q),
        .addr_lo (mem_addr[1:0]),
        .rdata   (mem_rdata),
        .data    (ext_data)
    );

    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        stall    = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = ST_REQ;
                    stall    = 1'b1;
                end
            end
            ST_REQ: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                if (mem_ack || timeout) state_nx = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_q      <= OP_LW;
            addr_err  <= 1'b0;
            bus_err   <= 1'b0;
            load_data <= '0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            mem_pc    <= '0;
        end else begin
            state    <= state_nx;
            addr_err <= misalign;
            if (accept) begin
                mem_addr  <= addr;
                mem_wdata <= wdata;
                mem_pc    <= pc;
                mem_write <= is_store(op_type);
                mem_be    <= be_for(op_type, addr[1:0]);
                op_q      <= op_type;
            end
            case (state)
                ST_REQ: begin
                    if (mem_ack) begin
                        cnt       <= '0;
                        load_data <= ext_data;
                        bus_err   <= 1'b0;
                    end else if (timeout) begin
                        cnt       <= '0;
                        load_data <= '0;
                        bus_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    load_data <= '0;
                    bus_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
